// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the 8-byte sequence generator/checker pair.
//
// Contents:
//   SEQ_LEN    number of bytes in one pattern period
//   SEQ        the cyclic byte pattern, index 0 first
//   SYNC_BYTE  first byte of the pattern; unique within it, so it is the lock word
//   state_t    checker state (HUNT / TRACK)
package seq_pkg;

  localparam int SEQ_LEN = 8;

  localparam logic [7:0] SEQ [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  localparam logic [7:0] SYNC_BYTE = 8'hAF;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/sequence_checker_sat_counter.sv
// sat_counter -- saturating up-counter with synchronous clear.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, count -> 0
//   clr    synchronous clear, wins over inc
//   inc    count up by one; holds at all-ones instead of wrapping
//   count  current value (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker -- receive-side checker for the 8-byte sequence generator.
//
// Hunts for SYNC_BYTE, then checks every qualified byte against the pattern,
// flagging mismatches and dropping lock after LOSS_THRESH consecutive errors.
// All outputs are registered (one cycle after the sampling edge).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   enable       byte qualifier
//   data[7:0]    stream byte
//   cnt_clr      synchronous clear of match_cnt / err_cnt
//   locked       1 while tracking
//   err_pulse    one-cycle pulse per mismatching byte while tracking
//   period_done  one-cycle pulse when the index-7 byte is consumed while tracking
//   exp_data     expected value of the next byte (SYNC_BYTE while hunting)
//   match_cnt    saturating count of matching bytes (lock byte included)
//   err_cnt      saturating count of mismatching bytes
//
// Build option:
//   SEQCHK_RESYNC_EN  when defined, a mismatching SYNC_BYTE while tracking is
//                     still flagged but re-aligns the index to 1 and keeps lock.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       data,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             period_done,
  output logic [7:0]       exp_data,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] consec_err;

  logic [2:0] idx_next;
  logic [3:0] consec_next;
  logic       byte_match;
  logic       match_inc;
  logic       err_inc;

  assign idx_next    = idx + 3'd1;
  assign consec_next = consec_err + 4'd1;
  assign byte_match  = (data == SEQ[idx]);

  // Counter increments follow the same decision the FSM makes on this edge,
  // so the counters update in step with the registered flags.
  always_comb begin
    match_inc = 1'b0;
    err_inc   = 1'b0;
    if (enable) begin
      if (state == HUNT) begin
        match_inc = (data == SYNC_BYTE);
      end else begin
        match_inc = byte_match;
        err_inc   = !byte_match;
      end
    end
  end

  // The index advances on every qualified byte in TRACK, match or not,
  // because the link is assumed not to slip; only a run of errors (or, with
  // re-sync enabled, a stray sync byte) changes alignment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      idx         <= 3'd0;
      consec_err  <= 4'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      period_done <= 1'b0;
      exp_data    <= SYNC_BYTE;
    end else begin
      err_pulse   <= 1'b0;
      period_done <= 1'b0;
      if (enable) begin
        case (state)
          HUNT: begin
            if (data == SYNC_BYTE) begin
              state      <= TRACK;
              idx        <= 3'd1;
              consec_err <= 4'd0;
              locked     <= 1'b1;
              exp_data   <= SEQ[1];
            end
          end
          TRACK: begin
            period_done <= (idx == 3'd7);
            if (byte_match) begin
              idx        <= idx_next;
              consec_err <= 4'd0;
              exp_data   <= SEQ[idx_next];
            end else begin
              err_pulse <= 1'b1;
`ifdef SEQCHK_RESYNC_EN
              if (data == SYNC_BYTE) begin
                idx        <= 3'd1;
                consec_err <= 4'd0;
                exp_data   <= SEQ[1];
              end else
`endif
              if (consec_next >= THRESH) begin
                state      <= HUNT;
                idx        <= 3'd0;
                consec_err <= 4'd0;
                locked     <= 1'b0;
                exp_data   <= SYNC_BYTE;
              end else begin
                idx        <= idx_next;
                consec_err <= consec_next;
                exp_data   <= SEQ[idx_next];
              end
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (match_inc),
    .count (match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (err_inc),
    .count (err_cnt)
  );

endmodule
